// File: rtl/mac_feeder.sv
// Operand sequencer for a single MAC instance: clears the accumulator, streams
// one operand pair per cycle from two shared-address buffers, then captures the sum.
module mac_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [LEN_WIDTH-1:0]      len,
  input  logic                      abort,
  output logic                      busy,
  output logic                      done,
  output logic                      rd_en,
  output logic [LEN_WIDTH-1:0]      rd_addr,
  input  logic [DATA_WIDTH-1:0]     a_rdata,
  input  logic [DATA_WIDTH-1:0]     b_rdata,
  output logic                      mac_clr,
  output logic                      mac_en,
  output logic [DATA_WIDTH-1:0]     mac_a,
  output logic [DATA_WIDTH-1:0]     mac_b,
  input  logic [3*DATA_WIDTH-1:0]   mac_cout,
  output logic [3*DATA_WIDTH-1:0]   result
);

  localparam int RES_WIDTH = 3 * DATA_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_FETCH   = 3'd2,
    S_FLUSH   = 3'd3,
    S_CAPTURE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [LEN_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic                   mac_en_q, mac_en_d;
  logic [RES_WIDTH-1:0]   result_q, result_d;
  logic                   accept_s;
  logic                   last_addr_s;
  logic                   fetch_s;

  // abort has priority over start, so a simultaneous pair leaves the feeder idle
  assign accept_s    = (state_q == S_IDLE) && start && !abort;
  assign last_addr_s = (rd_addr_q == (len_q - LEN_WIDTH'(1)));
  assign fetch_s     = (state_q == S_FETCH);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      rd_addr_q <= '0;
      mac_en_q  <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      rd_addr_q <= rd_addr_d;
      mac_en_q  <= mac_en_d;
      result_q  <= result_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_s) state_d = S_CLEAR;
          else          state_d = S_IDLE;
        end
        S_CLEAR: begin
          if (len_q != '0) state_d = S_FETCH;
          else             state_d = S_FLUSH;
        end
        S_FETCH: begin
          if (last_addr_s) state_d = S_FLUSH;
          else             state_d = S_FETCH;
        end
        S_FLUSH:   state_d = S_CAPTURE;
        S_CAPTURE: state_d = S_DONE;
        S_DONE:    state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // Length latch, address counter, MAC enable pipeline and result capture
  always_comb begin
    len_d     = len_q;
    rd_addr_d = rd_addr_q;
    mac_en_d  = 1'b0;
    result_d  = result_q;

    if (accept_s) begin
      len_d     = len;
      rd_addr_d = '0;
    end else begin
      len_d = len_q;
    end

    // address stops at len-1 instead of wrapping
    if (fetch_s && !abort && !last_addr_s) begin
      rd_addr_d = rd_addr_q + LEN_WIDTH'(1);
    end else begin
      rd_addr_d = accept_s ? '0 : rd_addr_q;
    end

    // an abort squashes the enable that would carry the in-flight read
    if (fetch_s && !abort) mac_en_d = 1'b1;
    else                   mac_en_d = 1'b0;

    if ((state_q == S_CAPTURE) && !abort) result_d = mac_cout;
    else                                  result_d = result_q;
  end

  // Output decode
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    rd_en   = 1'b0;
    mac_clr = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_CLEAR: begin
        busy    = 1'b1;
        mac_clr = 1'b1;
      end
      S_FETCH: begin
        busy  = 1'b1;
        rd_en = 1'b1;
      end
      S_FLUSH, S_CAPTURE: begin
        busy = 1'b1;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase

    rd_addr = rd_addr_q;
    mac_en  = mac_en_q;
    result  = result_q;
    if (mac_en_q) begin
      mac_a = a_rdata;
      mac_b = b_rdata;
    end else begin
      mac_a = '0;
      mac_b = '0;
    end
  end

endmodule

// File: tb/tb_mac_feeder.sv
// Directed bench for mac_feeder: behavioural operand buffers and MAC accumulator,
// a vector table of dot products, and hand-written abort/busy/reset sequences.
module tb_mac_feeder;

  localparam int DW = 8;
  localparam int LW = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [LW-1:0]   len = '0;
  logic            busy, done, rd_en, mac_clr, mac_en;
  logic [LW-1:0]   rd_addr;
  logic [DW-1:0]   a_rdata = '0;
  logic [DW-1:0]   b_rdata = '0;
  logic [DW-1:0]   mac_a, mac_b;
  logic [3*DW-1:0] mac_cout;
  logic [3*DW-1:0] result;

  logic [DW-1:0]   a_mem [0:255];
  logic [DW-1:0]   b_mem [0:255];
  logic [23:0]     acc;

  int total = 0;
  int passed = 0;

  typedef struct {
    int          len;
    logic [31:0] a_bytes;
    logic [31:0] b_bytes;
    logic [23:0] exp_result;
  } vec_t;

  vec_t vecs [6];

  mac_feeder #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
    .a_rdata(a_rdata), .b_rdata(b_rdata), .mac_clr(mac_clr), .mac_en(mac_en),
    .mac_a(mac_a), .mac_b(mac_b), .mac_cout(mac_cout), .result(result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en) begin
      a_rdata <= a_mem[rd_addr];
      b_rdata <= b_mem[rd_addr];
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)       acc <= '0;
    else if (mac_clr) acc <= '0;
    else if (mac_en)  acc <= acc + 24'(mac_a) * 24'(mac_b);
  end
  assign mac_cout = acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic fill_mem(input logic [7:0] a_val, input logic [7:0] b_val);
    for (int k = 0; k < 256; k++) begin
      a_mem[k] = a_val;
      b_mem[k] = b_val;
    end
  endtask

  // start at cycle 0, observe cycles 1..L+6; optional start pulses at bs1/bs2 with len=7
  task automatic run_dot(input int L, input logic [23:0] exp_res, input int bs1, input int bs2,
                         input string tag);
    int done_cnt = 0, done_cyc = -1, rd_cnt = 0, en_cnt = 0;
    int addr_err = 0, en_err = 0, clr_cnt = 0, clr_err = 0, overlap = 0;
    logic busy1 = 1'b0, busy_last = 1'b0, busy_after = 1'b1;
    logic [23:0] res_at_done = '0;
    @(negedge clk);
    start = 1'b1;
    len   = LW'(L);
    for (int cyc = 1; cyc <= L + 6; cyc++) begin
      @(negedge clk);
      if (mac_clr) begin
        clr_cnt++;
        if (cyc != 1) clr_err++;
      end
      if (rd_en) begin
        rd_cnt++;
        if (cyc < 2 || cyc > L + 1 || rd_addr !== LW'(cyc - 2)) addr_err++;
      end
      if (mac_en) begin
        en_cnt++;
        if (cyc < 3 || cyc > L + 2) en_err++;
      end
      if (mac_clr && mac_en) overlap++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        res_at_done = result;
      end
      if (cyc == 1)     busy1 = busy;
      if (cyc == L + 4) busy_last = busy;
      if (cyc == L + 5) busy_after = busy;
      start = 1'b0;
      if (cyc == bs1 || cyc == bs2) begin
        start = 1'b1;
        len   = 8'd7;
      end
    end
    start = 1'b0;
    check({tag, " clr_pulse"}, 32'(clr_cnt + 4 * clr_err), 32'd1);
    check({tag, " rd_en_count"}, 32'(rd_cnt), 32'(L));
    check({tag, " rd_addr_seq_errors"}, 32'(addr_err), 32'd0);
    check({tag, " mac_en_count"}, 32'(en_cnt), 32'(L));
    check({tag, " mac_en_window_errors"}, 32'(en_err), 32'd0);
    check({tag, " clr_en_overlap"}, 32'(overlap), 32'd0);
    check({tag, " done_count"}, 32'(done_cnt), 32'd1);
    check({tag, " done_cycle"}, 32'(done_cyc), 32'(L + 4));
    check({tag, " result"}, 32'(res_at_done), 32'(exp_res));
    check({tag, " busy_cycle1"}, 32'(busy1), 32'd1);
    check({tag, " busy_at_done"}, 32'(busy_last), 32'd1);
    check({tag, " busy_after_done"}, 32'(busy_after), 32'd0);
  endtask

  initial begin
    int done_seen;
    vecs[0] = '{4, {8'd4, 8'd3, 8'd2, 8'd1},       {8'd8, 8'd7, 8'd6, 8'd5},     24'd70};
    vecs[1] = '{0, {8'd9, 8'd9, 8'd9, 8'd9},       {8'd9, 8'd9, 8'd9, 8'd9},     24'd0};
    vecs[2] = '{1, {8'd0, 8'd0, 8'd0, 8'd9},       {8'd0, 8'd0, 8'd0, 8'd9},     24'd81};
    vecs[3] = '{2, {8'd0, 8'd0, 8'd3, 8'd3},       {8'd0, 8'd0, 8'd4, 8'd4},     24'd24};
    vecs[4] = '{3, {8'd0, 8'd255, 8'd255, 8'd255}, {8'd0, 8'd2, 8'd1, 8'd255},   24'd65790};
    vecs[5] = '{4, {8'd1, 8'd7, 8'd0, 8'd10},      {8'd200, 8'd3, 8'd50, 8'd10}, 24'd321};
    fill_mem(8'd0, 8'd0);

    #2;
    check("reset_ctrl", 32'({busy, done, rd_en, mac_clr, mac_en}), 32'd0);
    check("reset_rd_addr", 32'(rd_addr), 32'd0);
    check("reset_mac_ab", 32'({mac_a, mac_b}), 32'd0);
    check("reset_result", 32'(result), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      fill_mem(8'd0, 8'd0);
      for (int k = 0; k < 4; k++) begin
        a_mem[k] = vecs[i].a_bytes[8*k +: 8];
        b_mem[k] = vecs[i].b_bytes[8*k +: 8];
      end
      run_dot(vecs[i].len, vecs[i].exp_result, 0, 0, $sformatf("vec%0d", i));
    end

    // start pulses while busy, with len changed, are ignored
    fill_mem(8'd0, 8'd0);
    a_mem[0] = 8'd1; a_mem[1] = 8'd2; a_mem[2] = 8'd3; a_mem[3] = 8'd4;
    b_mem[0] = 8'd5; b_mem[1] = 8'd6; b_mem[2] = 8'd7; b_mem[3] = 8'd8;
    run_dot(4, 24'd70, 3, 6, "busy_start");

    fill_mem(8'd255, 8'd255);
    run_dot(255, 24'd16581375, 0, 0, "maxlen");

    // abort during FETCH: drop at cycle 6, no done, result kept
    @(negedge clk);
    start = 1'b1;
    len   = 8'd10;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("abort_pre_rd_en", 32'(rd_en), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_rd_en", 32'(rd_en), 32'd0);
    check("abort_mac_en", 32'(mac_en), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    done_seen = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    check("abort_result_kept", 32'(result), 32'd16581375);
    fill_mem(8'd0, 8'd0);
    a_mem[0] = 8'd3; a_mem[1] = 8'd3;
    b_mem[0] = 8'd4; b_mem[1] = 8'd4;
    run_dot(2, 24'd24, 0, 0, "after_abort");

    // abort together with start in IDLE wins
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("abort_start_idle_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("abort_start_idle_clr", 32'(mac_clr), 32'd0);

    // asynchronous reset in the middle of FETCH
    fill_mem(8'd5, 8'd5);
    @(negedge clk);
    start = 1'b1;
    len   = 8'd8;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(posedge clk);
    #2;
    check("pre_reset_mac_en", 32'(mac_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_ctrl", 32'({busy, done, rd_en, mac_clr, mac_en}), 32'd0);
    check("midrst_rd_addr", 32'(rd_addr), 32'd0);
    check("midrst_mac_ab", 32'({mac_a, mac_b}), 32'd0);
    check("midrst_result", 32'(result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_busy", 32'(busy), 32'd0);
    fill_mem(8'd0, 8'd0);
    a_mem[0] = 8'd9;
    b_mem[0] = 8'd9;
    run_dot(1, 24'd81, 0, 0, "after_reset");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
